// File: rtl/j_acc_deserializer.sv
// j_acc_deserializer: repacks an LSB-first bit-serial stream into DATA_WIDTH-bit words and writes them to SRAM.
// Latency: last valid bit -> SRAM write cycle is 1 clk (2 clk, read then add-write, with J_ACC_DESER_ADD_EN).
// Backpressure: none; serial_en gaps stall collection indefinitely and the SRAM is always assumed ready.
//
// Optional feature macro: J_ACC_DESER_ADD_EN
//   undefined : each completed word overwrites SRAM, sram_data_i is ignored.
//   defined   : each completed word is read-modify-written (SRAM += word, modulo 2^DATA_WIDTH).
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   store_start         one-cycle job start pulse, honoured only while idle
//   store_idle          high while no job is active
//   store_done          one-cycle pulse coincident with the job's final SRAM write
//   frame_err           sticky: serial_start seen mid-frame; cleared by reset or a new job
//   start_addr          first write address, sampled on store_start
//   img_size            number of words minus one, sampled on store_start
//   serial_input        data bit (from the shifter's serial_output)
//   serial_start        marks bit 0 of a frame, qualified by serial_en
//   serial_en           bit-valid strobe
//   sram_en, sram_we    SRAM access / write enables
//   sram_addr           SRAM address
//   sram_data_o         SRAM write data
//   sram_data_i         SRAM read data (one-cycle latency), used only in accumulate mode
module j_acc_deserializer #(
  parameter int SRAM_DEPTH = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int AW = $clog2(SRAM_DEPTH),
  localparam int BW = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  store_start,
  output logic                  store_idle,
  output logic                  store_done,
  output logic                  frame_err,
  input  logic [AW-1:0]         start_addr,
  input  logic [AW-1:0]         img_size,
  input  logic                  serial_input,
  input  logic                  serial_start,
  input  logic                  serial_en,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [AW-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;

  logic [BW-1:0]         bit_cnt;    // next bit position to fill in word
  logic [DATA_WIDTH-1:0] word;       // frame under collection
  logic [DATA_WIDTH-1:0] full_word;  // word with the in-flight final bit merged in
  logic [DATA_WIDTH-1:0] hold;       // completed word waiting for its SRAM write
  logic [AW-1:0]         word_cnt;   // index of the word being collected
  logic [AW-1:0]         last_cnt;   // index of the final word of the job
  logic [AW-1:0]         cur_addr;   // SRAM address of the next write
  logic                  wr_pend;    // write issues this cycle

  logic                  job_start;
  logic                  bit_vld;
  logic                  frame_restart;
  logic                  word_done;
  logic                  last_word;

`ifdef J_ACC_DESER_ADD_EN
  logic                  rd_pend;    // read of the accumulation target issues this cycle
`else
  logic                  unused_sram_data;
  assign unused_sram_data = ^sram_data_i;
`endif

  assign job_start     = (state == IDLE) && store_start;
  assign bit_vld       = (state == RECV) && serial_en;
  // A frame marker that arrives mid-word restarts collection at bit 0.
  assign frame_restart = bit_vld && serial_start && (bit_cnt != '0);
  assign word_done     = bit_vld && !frame_restart && (bit_cnt == LAST_BIT);
  assign last_word     = (word_cnt == last_cnt);

  // The final bit goes straight into hold, so it is merged here rather than
  // taking an extra cycle through word.
  always_comb begin
    full_word                 = word;
    full_word[DATA_WIDTH-1]   = serial_input;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    store_idle  = 1'b0;
    store_done  = 1'b0;
    sram_en     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = cur_addr;
    sram_data_o = '0;

    case (state)
      IDLE: begin
        store_idle = 1'b1;
        if (store_start) begin
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (word_done && last_word) begin
          state_nxt = LAST;
        end
      end
      LAST: begin
        // Only the final word's write can be pending here.
        if (wr_pend) begin
          store_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef J_ACC_DESER_ADD_EN
    sram_en = rd_pend | wr_pend;
    sram_we = wr_pend;
    if (wr_pend) begin
      sram_data_o = sram_data_i + hold;
    end
`else
    sram_en = wr_pend;
    sram_we = wr_pend;
    if (wr_pend) begin
      sram_data_o = hold;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Bit collection and write pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      word      <= '0;
      hold      <= '0;
      word_cnt  <= '0;
      last_cnt  <= '0;
      cur_addr  <= '0;
      wr_pend   <= 1'b0;
      frame_err <= 1'b0;
`ifdef J_ACC_DESER_ADD_EN
      rd_pend   <= 1'b0;
`endif
    end else begin
      // Write pipe: each pending access lasts exactly one cycle.
`ifdef J_ACC_DESER_ADD_EN
      rd_pend <= 1'b0;
      wr_pend <= rd_pend;
`else
      wr_pend <= 1'b0;
`endif
      if (wr_pend) begin
        cur_addr <= cur_addr + 1'b1;
      end

      if (job_start) begin
        cur_addr  <= start_addr;
        last_cnt  <= img_size;
        word_cnt  <= '0;
        bit_cnt   <= '0;
        word      <= '0;
        frame_err <= 1'b0;
      end

      if (bit_vld) begin
        if (frame_restart) begin
          frame_err <= 1'b1;
          word      <= DATA_WIDTH'(serial_input);
          bit_cnt   <= BW'(1);
        end else if (bit_cnt == LAST_BIT) begin
          hold    <= full_word;
          word    <= '0;
          bit_cnt <= '0;
`ifdef J_ACC_DESER_ADD_EN
          rd_pend <= 1'b1;
`else
          wr_pend <= 1'b1;
`endif
          if (!last_word) begin
            word_cnt <= word_cnt + 1'b1;
          end
        end else begin
          word[bit_cnt] <= serial_input;
          bit_cnt       <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_j_acc_deserializer.sv
// tb_j_acc_deserializer: drives LSB-first serial frames into j_acc_deserializer and scores SRAM traffic.
// Reference: an expected write list per job (address sequence, word or accumulated sum) plus a shadow RAM.
// Stimulus: directed jobs followed by randomised jobs with gaps, stray starts, idle noise and broken frames.
module tb_j_acc_deserializer;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 32;
`ifdef J_ACC_DESER_ADD_EN
  localparam bit ADD = 1'b1;
`else
  localparam bit ADD = 1'b0;
`endif
  localparam int LAT = ADD ? 2 : 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          store_start;
  logic          store_idle;
  logic          store_done;
  logic          frame_err;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] img_size;
  logic          serial_input;
  logic          serial_start;
  logic          serial_en;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_o;
  logic [DW-1:0] sram_data_i;

  always #5 clk = ~clk;

  j_acc_deserializer dut (
    .clk          (clk),
    .reset        (reset),
    .store_start  (store_start),
    .store_idle   (store_idle),
    .store_done   (store_done),
    .frame_err    (frame_err),
    .start_addr   (start_addr),
    .img_size     (img_size),
    .serial_input (serial_input),
    .serial_start (serial_start),
    .serial_en    (serial_en),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_data_o  (sram_data_o),
    .sram_data_i  (sram_data_i)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model with one-cycle read latency
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rd_q;
  logic          mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
    end else if (sram_en && sram_we) begin
      mem[sram_addr] <= sram_data_o;
    end
    if (sram_en && !sram_we) rd_q <= mem[sram_addr];
  end
  assign sram_data_i = rd_q;

  // Bus monitor
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_dat_q[$];
  int            wr_cyc_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            rd_cnt   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (sram_en && sram_we) begin
        wr_addr_q.push_back(sram_addr);
        wr_dat_q.push_back(sram_data_o);
        wr_cyc_q.push_back(cyc);
      end
      if (sram_en && !sram_we) rd_cnt <= rd_cnt + 1;
      if (store_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  // Reference state
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] job_words[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] exp_write(input logic [AW-1:0] a, input logic [DW-1:0] w);
    logic [DW-1:0] e;
    e = ADD ? ref_mem[a] + w : w;
    ref_mem[a] = e;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap: 0 = serial_en held high, 1 = one idle cycle before every bit, 2 = random 0..2 idle cycles
  task automatic send_bit(input logic b, input logic st, input int gap, input bit stray, output int dcyc);
    int n;
    n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int k = 0; k < n; k++) begin
      serial_en    = 1'b0;
      serial_input = 1'($urandom);
      serial_start = 1'($urandom);
      tick();
    end
    serial_en    = 1'b1;
    serial_input = b;
    serial_start = st;
    store_start  = stray && ($urandom_range(0, 7) == 0);
    dcyc         = cyc;
    tick();
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap, input bit stray, output int dcyc);
    for (int i = 0; i < DW; i++) send_bit(w[i], i == 0, gap, stray, dcyc);
  endtask

  task automatic send_junk(input int nbits, input int gap);
    int d;
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom), i == 0, gap, 1'b0, d);
  endtask

  task automatic idle_noise();
    for (int i = 0; i < 6; i++) begin
      serial_en    = 1'($urandom);
      serial_input = 1'($urandom);
      serial_start = 1'($urandom);
      tick();
    end
    serial_en = 1'b0;
  endtask

  task automatic start_job(input int sa, input int sz);
    start_addr  = AW'(sa);
    img_size    = AW'(sz);
    store_start = 1'b1;
    tick();
    store_start = 1'b0;
    start_addr  = AW'($urandom);
    img_size    = AW'($urandom);
    chk("idle_drop", 64'(store_idle), 64'(0));
    chk("ferr_clear", 64'(frame_err), 64'(0));
  endtask

  task automatic run_job(input int sa, input int sz, input int gap, input bit stray, input int junk);
    int            bw, bd, br, dcyc, n;
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    int            lc[$];
    if (stray) idle_noise();
    bw = wr_addr_q.size();
    bd = done_cnt;
    br = rd_cnt;
    start_job(sa, sz);
    if (junk > 0) send_junk(junk, gap);
    for (int i = 0; i <= sz; i++) begin
      ea.push_back(AW'(sa + i));
      ed.push_back(exp_write(AW'(sa + i), job_words[i]));
      send_word(job_words[i], gap, stray, dcyc);
      lc.push_back(dcyc);
    end
    store_start  = 1'b0;
    serial_en    = 1'b0;
    serial_start = 1'b0;
    n = 0;
    while (!store_idle && n < 20) begin
      tick();
      n++;
    end
    chk("job_end_idle", 64'(store_idle), 64'(1));
    repeat (3) tick();
    chk("wr_count", 64'(wr_addr_q.size() - bw), 64'(sz + 1));
    chk("rd_count", 64'(rd_cnt - br), 64'(ADD ? sz + 1 : 0));
    chk("done_count", 64'(done_cnt - bd), 64'(1));
    chk("frame_err", 64'(frame_err), 64'(junk > 0));
    for (int i = 0; i <= sz && bw + i < wr_addr_q.size(); i++) begin
      chk("wr_addr", 64'(wr_addr_q[bw + i]), 64'(ea[i]));
      chk("wr_data", 64'(wr_dat_q[bw + i]), 64'(ed[i]));
      chk("wr_latency", 64'(wr_cyc_q[bw + i]), 64'(lc[i] + LAT));
      chk("ram", 64'(mem[ea[i]]), 64'(ed[i]));
    end
    if (wr_addr_q.size() > bw) chk("done_with_last_wr", 64'(done_cyc), 64'(wr_cyc_q[wr_addr_q.size() - 1]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int            bw, dcyc, sz, sa, gap, junk;
    logic [DW-1:0] w;
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];

    reset        = 1'b1;
    store_start  = 1'b0;
    start_addr   = '0;
    img_size     = '0;
    serial_input = 1'b0;
    serial_start = 1'b0;
    serial_en    = 1'b0;
    mem_clr      = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i[AW-1:0]] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle", 64'(store_idle), 64'(1));
    chk("rst_done", 64'(store_done), 64'(0));
    chk("rst_ferr", 64'(frame_err), 64'(0));
    chk("rst_en", 64'(sram_en), 64'(0));
    chk("rst_we", 64'(sram_we), 64'(0));
    chk("rst_addr", 64'(sram_addr), 64'(0));
    chk("rst_data", 64'(sram_data_o), 64'(0));
    mem_clr = 1'b0;
    #3 reset = 1'b0;
    tick();

    // Accumulate / overwrite at address 4: 5, then 7, then 7 again
    job_words.delete(); job_words.push_back(32'd5);
    run_job(4, 0, 0, 1'b0, 0);
    job_words.delete(); job_words.push_back(32'd7);
    run_job(4, 0, 0, 1'b0, 0);
    run_job(4, 0, 0, 1'b0, 0);
    chk("acc_ram4", 64'(mem[4]), 64'(ADD ? 19 : 7));

    // Continuous stream of words 0..9
    job_words.delete();
    for (int i = 0; i < 10; i++) job_words.push_back(DW'(i));
    run_job(0, 9, 0, 1'b0, 0);

    // Single word with serial_en toggling every cycle
    job_words.delete(); job_words.push_back(32'hDEAD_BEEF);
    run_job(37, 0, 1, 1'b0, 0);

    // Frame marker at bit 5 of a broken frame, then a good frame
    job_words.delete(); job_words.push_back(32'h0000_00A5);
    run_job(200, 0, 0, 1'b0, 5);

    // Address wrap
    job_words.delete();
    job_words.push_back(32'd1); job_words.push_back(32'd2); job_words.push_back(32'd3);
    run_job(1023, 2, 0, 1'b0, 0);

    // Reset during bit 12 of word 3 of a 10-word job
    job_words.delete();
    for (int i = 0; i < 10; i++) job_words.push_back($urandom);
    bw = wr_addr_q.size();
    start_job(300, 9);
    for (int i = 0; i < 3; i++) begin
      ea.push_back(AW'(300 + i));
      ed.push_back(exp_write(AW'(300 + i), job_words[i]));
      send_word(job_words[i], 0, 1'b0, dcyc);
    end
    w = job_words[3];
    for (int b = 0; b < 12; b++) send_bit(w[b], b == 0, 0, 1'b0, dcyc);
    serial_en    = 1'b1;
    serial_input = w[12];
    serial_start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", 64'(sram_we), 64'(0));
    chk("midrst_en", 64'(sram_en), 64'(0));
    chk("midrst_idle", 64'(store_idle), 64'(1));
    chk("midrst_done", 64'(store_done), 64'(0));
    repeat (2) tick();
    serial_en = 1'b0;
    #3 reset = 1'b0;
    idle_noise();
    repeat (3) tick();
    chk("midrst_writes", 64'(wr_addr_q.size() - bw), 64'(3));
    for (int i = 0; i < 3; i++) chk("midrst_ram", 64'(mem[ea[i]]), 64'(ed[i]));

    job_words.delete(); job_words.push_back(32'h0000_0055);
    run_job(0, 0, 0, 1'b0, 0);

    // Randomised jobs
    for (int j = 0; j < 8; j++) begin
      sz   = int'($urandom_range(0, 6));
      sa   = int'($urandom_range(0, DEPTH - 1));
      gap  = ($urandom_range(0, 1) == 0) ? 0 : 2;
      junk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 0;
      job_words.delete();
      for (int i = 0; i <= sz; i++) job_words.push_back($urandom);
      run_job(sa, sz, gap, 1'b1, junk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
